adc_burst_fifo: RTL

- Sits directly downstream of the ADC burst readout stage and consumes its `write`/`writedata` word stream (one word per sync pulse while a burst runs) plus its `running` level.
- Frames each burst as a packet by tagging the first and last word.
- Buffers packets in an on-chip FIFO and presents them as an Avalon-ST source with sop/eop to the DMA/USB readout path.
- Counts and flags words dropped on overflow.

---
 rtl/adc_burst_fifo_pkg.sv | 16 +
 rtl/adc_sfifo.sv | 74 +++++++
 rtl/adc_burst_fifo.sv | 134 +++++++++++++
 3 files changed

// File: rtl/adc_burst_fifo_pkg.sv
// Shared constants for the ADC burst FIFO: readout-word field positions and
// the drop counter ceiling.
package adc_burst_fifo_pkg;

  // Readout word layout: [15] start, [14] stop, [13] zero, [12] overrange,
  // [11:0] sample. The FIFO passes words through untouched; these positions
  // exist so neighbouring blocks and benches agree on the layout.
  localparam int START_BIT  = 15;
  localparam int STOP_BIT   = 14;
  localparam int OR_BIT     = 12;
  localparam int SAMPLE_MSB = 11;

  // Dropped-word counter saturates here instead of wrapping.
  localparam logic [15:0] DROP_MAX = 16'hFFFF;

endpackage

// File: rtl/adc_sfifo.sv
// Synchronous FIFO with a registered output stage. The output register counts
// toward capacity, so at most 2^AW words are held in total (memory + output).
module adc_sfifo #(
  parameter int AW = 10,
  parameter int W  = 17
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  output logic          out_valid,
  output logic [W-1:0]  out_data,
  output logic          full,
  output logic [AW:0]   level
);

  localparam int DEPTH = 1 << AW;
  localparam logic [AW:0] FULL_LEVEL = {1'b1, {AW{1'b0}}};

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   mem_count;
  logic          do_pop;
  logic          do_push;
  logic          load;

  // Handshake qualification: a pop frees the output slot before the push is
  // judged, so push-while-full succeeds whenever a word leaves that cycle.
  assign do_pop  = pop && out_valid;
  assign do_push = push && (!full || do_pop);
  assign load    = (mem_count != '0) && (!out_valid || do_pop);
  assign level   = mem_count + {{AW{1'b0}}, out_valid};
  assign full    = (level == FULL_LEVEL);

  // Storage array write port.
  // NOTE: the memory array has no reset; pointers and count define validity, and a reset would prevent RAM inference.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointer and occupancy bookkeeping for the storage array.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      mem_count <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (load)    rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, load})
        2'b10:   mem_count <= mem_count + 1'b1;
        2'b01:   mem_count <= mem_count - 1'b1;
        default: mem_count <= mem_count;
      endcase
    end
  end

  // Registered output stage: refill from memory when empty or being consumed.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= mem[rd_ptr];
    end else if (do_pop) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/adc_burst_fifo.sv
// Frames ADC readout bursts into sop/eop packets and buffers them for an
// Avalon-ST consumer. Each word is held in a one-deep staging register until
// the next word or the burst end reveals whether it is the last of its burst.
module adc_burst_fifo
  import adc_burst_fifo_pkg::*;
#(
  parameter int AW = 10,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          write,
  input  logic [DW-1:0] writedata,
  input  logic          running,
  input  logic          clear,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          out_sop,
  output logic          out_eop,
  output logic [AW:0]   level,
  output logic          overflow,
  output logic [15:0]   drop_cnt
);

  logic          running_d;
  logic          burst_end;
  logic          stg_valid;
  logic          stg_eop;
  logic [DW-1:0] stg_data;
  logic          sop_pending;

  logic          fifo_full;
  logic          fifo_pop;
  logic [DW:0]   fifo_q;
  logic          push_ok;
  logic          push;
  logic          push_eop;
  logic          load_new;
  logic          drop;

  assign burst_end = running_d && !running;
  assign fifo_pop  = out_valid && out_ready;
  assign push_ok   = !fifo_full || fifo_pop;

  // Staging decisions: push the held word, accept the new word, or drop it.
  // A staged word marked eop is never displaced, so framing survives overflow.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    push     = 1'b0;
    load_new = 1'b0;
    drop     = 1'b0;
    push_eop = stg_eop || (burst_end && !write);
    if (stg_valid) begin
      if (write) begin
        if (push_ok) begin
          push     = 1'b1;
          load_new = 1'b1;
        end else begin
          drop     = 1'b1;
        end
      end else if (push_eop) begin
        push = push_ok;
      end
    end else if (write) begin
      load_new = 1'b1;
    end
  end

  // Burst edge detector and staging register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      running_d <= 1'b0;
      stg_valid <= 1'b0;
      stg_eop   <= 1'b0;
      stg_data  <= '0;
    end else begin
      running_d <= running;
      if (load_new) begin
        stg_valid <= 1'b1;
        stg_data  <= writedata;
        stg_eop   <= burst_end;
      end else if (push) begin
        stg_valid <= 1'b0;
        stg_eop   <= 1'b0;
      end else if (stg_valid && burst_end) begin
        stg_eop   <= 1'b1;
      end
    end
  end

  // Overflow accounting; a clear coinciding with a drop still counts that drop.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (clear) begin
      overflow <= drop;
      drop_cnt <= {15'd0, drop};
    end else if (drop) begin
      overflow <= 1'b1;
      if (drop_cnt != DROP_MAX) drop_cnt <= drop_cnt + 16'd1;
    end
  end

  // Start-of-packet tracker: the word after an eop transfer opens a packet.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sop_pending <= 1'b1;
    end else if (fifo_pop) begin
      sop_pending <= fifo_q[DW];
    end
  end

  adc_sfifo #(
    .AW (AW),
    .W  (DW + 1)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (push),
    .push_data ({push_eop, stg_data}),
    .pop       (out_ready),
    .out_valid (out_valid),
    .out_data  (fifo_q),
    .full      (fifo_full),
    .level     (level)
  );

  assign out_data = fifo_q[DW-1:0];
  assign out_eop  = out_valid && fifo_q[DW];
  assign out_sop  = out_valid && sop_pending;

endmodule
